// File: rtl/tx_arbiter_if.sv
// Bundle between the byte sources, the arbiter and the shared serial transmitter.
// master: requester/transmitter side; slave: the arbiter itself.
interface tx_arbiter_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic           send_en;
   logic [7:0]     send_data;
   logic           send_done;
   logic           err;

   modport master (
      output req, req_data, send_done,
      input  grant, done, busy, send_en, send_data, err
   );

   modport slave (
      input  req, req_data, send_done,
      output grant, done, busy, send_en, send_data, err
   );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial byte transmitter among N requesters.
// Optional `TX_TIMEOUT_EN adds a SEND watchdog that aborts with an err pulse.
module tx_arbiter #(
   parameter int unsigned N              = 4,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   tx_arbiter_if.slave  bus
);
   localparam int unsigned PW = $clog2(N);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_idx;
   logic [GW-1:0]   r_gap_cnt;
   logic [N-1:0]    r_grant;
   logic [N-1:0]    r_done;
   logic            r_busy;
   logic            r_send_en;
   logic [7:0]      r_send_data;

   logic            w_found;
   logic [PW-1:0]   w_idx;
   logic [7:0]      w_byte;
   logic            w_timeout;
   int              w_cand;

   // First requester at or after r_ptr, wrapping explicitly at N-1
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = 0;
      w_byte  = '0;
      for (int i = 0; i < N; i++) begin
         w_cand = int'(r_ptr) + i;
         if (w_cand > int'(N - 1)) w_cand = w_cand - int'(N);
         if (!w_found && bus.req[PW'(w_cand)]) begin
            w_found = 1'b1;
            w_idx   = PW'(w_cand);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (w_idx == PW'(i)) w_byte = bus.req_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_idx       <= '0;
         r_gap_cnt   <= '0;
         r_grant     <= '0;
         r_done      <= '0;
         r_busy      <= 1'b0;
         r_send_en   <= 1'b0;
         r_send_data <= '0;
      end else begin
         r_done <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_idx       <= w_idx;
                  r_grant     <= N'(1) << w_idx;
                  r_send_data <= w_byte;
                  r_send_en   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_SEND;
               end
            end
            S_SEND: begin
               if (bus.send_done || w_timeout) begin
                  r_send_en <= 1'b0;
                  r_done    <= r_grant;
                  r_grant   <= '0;
                  r_ptr     <= (r_idx == PW'(N - 1)) ? '0 : r_idx + 1'b1;
                  r_gap_cnt <= '0;
                  r_state   <= S_GAP;
               end
            end
            S_GAP: begin
               // The done cycle is the first GAP cycle
               if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  r_gap_cnt <= '0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef TX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_wdog;
   logic          r_err;

   assign w_timeout = (r_wdog == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog sits at zero outside SEND, so it is clear on every SEND entry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= (r_state == S_SEND) && w_timeout && !bus.send_done;
         if (r_state == S_SEND) r_wdog <= r_wdog + 1'b1;
         else                   r_wdog <= '0;
      end
   end

   assign bus.err = r_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_timeout        = 1'b0;
   assign bus.err          = 1'b0;
`endif

   assign bus.grant     = r_grant;
   assign bus.done      = r_done;
   assign bus.busy      = r_busy;
   assign bus.send_en   = r_send_en;
   assign bus.send_data = r_send_data;
endmodule
